instr_sequencer: RTL and testbench

Fetch-decode-execute control unit for the 16-bit processor core. It latches the instruction word presented by the ROM into an instruction register and classifies it by the top opcode nibble. It then drives the mutually exclusive bus read-enables and the PC advance strobe for the ALU register file, RAM and PC blocks. It also counts retired instructions and stops the core on a halt or illegal opcode.

---
 rtl/instr_sequencer_if.sv | 32 +++
 rtl/instr_sequencer.sv | 125 ++++++++++++
 tb/tb_instr_sequencer.sv | 265 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/instr_sequencer_if.sv
// Bus bundle between the instruction sequencer and the ROM/ALU/RAM/PC blocks.
// The sequencer uses the slave view; the environment driving ROM and run uses master.
interface instr_sequencer_if #(
  parameter int DATA_WIDTH  = 16,
  parameter int COUNT_WIDTH = 16
);
  logic                   run;
  logic [DATA_WIDTH-1:0]  rom_opcode;
  logic [DATA_WIDTH-1:0]  rom_operand;
  logic [DATA_WIDTH-1:0]  ir_opcode;
  logic [DATA_WIDTH-1:0]  ir_operand;
  logic                   pc_read_enable;
  logic                   pc_enable;
  logic                   alu_read_enable;
  logic                   ram_read_enable;
  logic [2:0]             state;
  logic                   halted;
  logic                   illegal;
  logic [COUNT_WIDTH-1:0] instr_count;

  modport master (
    output run, rom_opcode, rom_operand,
    input  ir_opcode, ir_operand, pc_read_enable, pc_enable, alu_read_enable,
           ram_read_enable, state, halted, illegal, instr_count
  );

  modport slave (
    input  run, rom_opcode, rom_operand,
    output ir_opcode, ir_operand, pc_read_enable, pc_enable, alu_read_enable,
           ram_read_enable, state, halted, illegal, instr_count
  );
endinterface

// File: rtl/instr_sequencer.sv
// Fetch-decode-execute control: latches the ROM word, classifies it by the top
// opcode nibble and sequences the mutually exclusive bus read-enables and PC strobe.
module instr_sequencer #(
  parameter int DATA_WIDTH  = 16,
  parameter int RAM_LATENCY = 1,
  parameter int COUNT_WIDTH = 16
) (
  input  logic             clk,
  input  logic             reset,
  instr_sequencer_if.slave bus
);
  typedef enum logic [2:0] {
    FETCH  = 3'd0,
    DECODE = 3'd1,
    EXEC   = 3'd2,
    WAIT   = 3'd3,
    RETIRE = 3'd4,
    HALT   = 3'd5
  } state_e;

  localparam logic [3:0] CLS_ALU = 4'h1;
  localparam logic [3:0] CLS_ROM = 4'h3;
  localparam logic [3:0] CLS_RAM = 4'h4;
  localparam logic [3:0] CLS_PC  = 4'h7;
  // EXEC already supplies one RAM cycle and WAIT exits on zero, hence the -2.
  localparam logic [3:0] WAIT_LOAD = 4'((RAM_LATENCY > 1) ? RAM_LATENCY - 2 : 0);

  state_e                 state_q, state_d;
  logic [DATA_WIDTH-1:0]  ir_opcode_q, ir_opcode_d;
  logic [DATA_WIDTH-1:0]  ir_operand_q, ir_operand_d;
  logic [COUNT_WIDTH-1:0] instr_count_q, instr_count_d;
  logic [3:0]             wait_q, wait_d;
  logic                   halted_q, halted_d;
  logic                   illegal_q, illegal_d;
  logic [3:0]             cls;

  assign cls = ir_opcode_q[DATA_WIDTH-1 -: 4];

  always_comb begin
    state_d       = state_q;
    ir_opcode_d   = ir_opcode_q;
    ir_operand_d  = ir_operand_q;
    instr_count_d = instr_count_q;
    wait_d        = wait_q;
    halted_d      = halted_q;
    illegal_d     = illegal_q;
    case (state_q)
      FETCH: begin
        if (bus.run) begin
          ir_opcode_d  = bus.rom_opcode;
          ir_operand_d = bus.rom_operand;
          state_d      = DECODE;
        end
      end
      DECODE: begin
        if (cls == CLS_ALU || cls == CLS_ROM || cls == CLS_RAM || cls == CLS_PC) begin
          state_d = EXEC;
        end else begin
          state_d   = HALT;
          halted_d  = 1'b1;
          illegal_d = (ir_opcode_q != '0);
        end
      end
      EXEC: begin
        if (cls == CLS_RAM && RAM_LATENCY > 1) begin
          wait_d  = WAIT_LOAD;
          state_d = WAIT;
        end else begin
          // Count on entry to RETIRE so the retire cycle already shows the new total.
          instr_count_d = instr_count_q + COUNT_WIDTH'(1);
          state_d       = RETIRE;
        end
      end
      WAIT: begin
        if (wait_q == 4'd0) begin
          instr_count_d = instr_count_q + COUNT_WIDTH'(1);
          state_d       = RETIRE;
        end else begin
          wait_d = wait_q - 4'd1;
        end
      end
      RETIRE: state_d = FETCH;
      HALT:   state_d = HALT;
      default: begin
        state_d   = HALT;
        halted_d  = 1'b1;
        illegal_d = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= FETCH;
      ir_opcode_q   <= '0;
      ir_operand_q  <= '0;
      instr_count_q <= '0;
      wait_q        <= '0;
      halted_q      <= 1'b0;
      illegal_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      ir_opcode_q   <= ir_opcode_d;
      ir_operand_q  <= ir_operand_d;
      instr_count_q <= instr_count_d;
      wait_q        <= wait_d;
      halted_q      <= halted_d;
      illegal_q     <= illegal_d;
    end
  end

  // Each read-enable is tied to a distinct state (or EXEC class), so they never overlap.
  assign bus.pc_read_enable  = !reset && state_q == FETCH && bus.run;
  assign bus.alu_read_enable = !reset && state_q == EXEC && cls == CLS_ALU;
  assign bus.ram_read_enable = !reset && ((state_q == EXEC && cls == CLS_RAM) || state_q == WAIT);
  assign bus.pc_enable       = !reset && ((state_q == EXEC && cls == CLS_PC) ||
                                          (state_q == RETIRE && cls != CLS_PC));

  assign bus.ir_opcode   = ir_opcode_q;
  assign bus.ir_operand  = ir_operand_q;
  assign bus.state       = state_q;
  assign bus.halted      = halted_q;
  assign bus.illegal     = illegal_q;
  assign bus.instr_count = instr_count_q;
endmodule

// File: tb/tb_instr_sequencer.sv
// Bench for instr_sequencer: two instances (RAM latency 3 / 16-bit count, latency 1 / 4-bit
// count) share stimulus and are checked every cycle against an instruction-timeline model.
module tb_instr_sequencer;
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        run = 1'b0;
  logic [15:0] rom_op = '0;
  logic [15:0] rom_opd = '0;
  int nvec = 0;
  int nerr = 0;

  always #5 clk = ~clk;

  instr_sequencer_if #(.DATA_WIDTH(16), .COUNT_WIDTH(16)) if0 ();
  instr_sequencer_if #(.DATA_WIDTH(16), .COUNT_WIDTH(4))  if1 ();

  assign if0.run = run;
  assign if0.rom_opcode = rom_op;
  assign if0.rom_operand = rom_opd;
  assign if1.run = run;
  assign if1.rom_opcode = rom_op;
  assign if1.rom_operand = rom_opd;

  instr_sequencer #(.DATA_WIDTH(16), .RAM_LATENCY(3), .COUNT_WIDTH(16)) u0 (
    .clk(clk), .reset(reset), .bus(if0.slave));
  instr_sequencer #(.DATA_WIDTH(16), .RAM_LATENCY(1), .COUNT_WIDTH(4)) u1 (
    .clk(clk), .reset(reset), .bus(if1.slave));

  logic [2:0]  o_st[2];
  logic [15:0] o_op[2], o_opd[2], o_cnt[2];
  logic        o_pre[2], o_pe[2], o_ae[2], o_re[2], o_hlt[2], o_ill[2];

  always_comb begin
    o_st[0] = if0.state;  o_op[0] = if0.ir_opcode;  o_opd[0] = if0.ir_operand;
    o_cnt[0] = if0.instr_count;
    o_pre[0] = if0.pc_read_enable; o_pe[0] = if0.pc_enable;
    o_ae[0] = if0.alu_read_enable; o_re[0] = if0.ram_read_enable;
    o_hlt[0] = if0.halted; o_ill[0] = if0.illegal;
    o_st[1] = if1.state;  o_op[1] = if1.ir_opcode;  o_opd[1] = if1.ir_operand;
    o_cnt[1] = 16'(if1.instr_count);
    o_pre[1] = if1.pc_read_enable; o_pe[1] = if1.pc_enable;
    o_ae[1] = if1.alu_read_enable; o_re[1] = if1.ram_read_enable;
    o_hlt[1] = if1.halted; o_ill[1] = if1.illegal;
  end

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- reference model: each fetched instruction expands into a cycle timeline
  typedef struct packed {
    logic [2:0] st;
    logic pe, ae, re, inc, hlt, ill;
  } step_t;

  localparam int          LAT   [2] = '{3, 1};
  localparam logic [15:0] CMASK [2] = '{16'hFFFF, 16'h000F};

  step_t       tl[2][0:19];
  int          tl_len[2], tl_idx[2];
  step_t       cur[2];
  logic [15:0] m_op[2], m_opd[2], m_cnt[2];
  logic        m_halt[2], m_ill[2];

  function automatic step_t mk(int st, int pe, int ae, int re, int inc, int hlt, int ill);
    step_t s;
    s.st = 3'(st); s.pe = (pe != 0); s.ae = (ae != 0); s.re = (re != 0);
    s.inc = (inc != 0); s.hlt = (hlt != 0); s.ill = (ill != 0);
    return s;
  endfunction

  task automatic push(int d, step_t s);
    tl[d][tl_len[d]] = s;
    tl_len[d]++;
  endtask

  task automatic build(int d, logic [15:0] op);
    tl_len[d] = 0;
    push(d, mk(1, 0, 0, 0, 0, 0, 0));
    case (op[15:12])
      4'h1: begin push(d, mk(2, 0, 1, 0, 0, 0, 0)); push(d, mk(4, 1, 0, 0, 1, 0, 0)); end
      4'h3: begin push(d, mk(2, 0, 0, 0, 0, 0, 0)); push(d, mk(4, 1, 0, 0, 1, 0, 0)); end
      4'h7: begin push(d, mk(2, 1, 0, 0, 0, 0, 0)); push(d, mk(4, 0, 0, 0, 1, 0, 0)); end
      4'h4: begin
        push(d, mk(2, 0, 0, 1, 0, 0, 0));
        for (int i = 1; i < LAT[d]; i++) push(d, mk(3, 0, 0, 1, 0, 0, 0));
        push(d, mk(4, 1, 0, 0, 1, 0, 0));
      end
      default: push(d, mk(5, 0, 0, 0, 0, 1, (op != 16'h0000) ? 1 : 0));
    endcase
  endtask

  task automatic enter(int d, step_t s);
    cur[d] = s;
    if (s.inc) m_cnt[d] = (m_cnt[d] + 16'd1) & CMASK[d];
    if (s.hlt) m_halt[d] = 1'b1;
    if (s.ill) m_ill[d] = 1'b1;
  endtask

  task automatic mreset(int d);
    cur[d] = mk(0, 0, 0, 0, 0, 0, 0);
    tl_len[d] = 0; tl_idx[d] = 0;
    m_op[d] = '0; m_opd[d] = '0; m_cnt[d] = '0;
    m_halt[d] = 1'b0; m_ill[d] = 1'b0;
  endtask

  initial begin
    for (int d = 0; d < 2; d++) mreset(d);
    forever begin
      @(posedge clk or posedge reset);
      for (int d = 0; d < 2; d++) begin
        if (reset) mreset(d);
        else if (tl_idx[d] < tl_len[d]) begin
          enter(d, tl[d][tl_idx[d]]);
          tl_idx[d]++;
        end else if (cur[d].st == 3'd5) begin
          cur[d] = cur[d];
        end else if (cur[d].st == 3'd0 && run) begin
          m_op[d] = rom_op; m_opd[d] = rom_opd;
          build(d, rom_op);
          enter(d, tl[d][0]);
          tl_idx[d] = 1;
        end else begin
          cur[d] = mk(0, 0, 0, 0, 0, 0, 0);
        end
      end
    end
  end

  // ---------------- per-cycle compare, mid-cycle
  initial forever begin
    @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      chk($sformatf("u%0d.state", d), o_st[d], cur[d].st);
      chk($sformatf("u%0d.ir_opcode", d), o_op[d], m_op[d]);
      chk($sformatf("u%0d.ir_operand", d), o_opd[d], m_opd[d]);
      chk($sformatf("u%0d.instr_count", d), o_cnt[d], m_cnt[d]);
      chk($sformatf("u%0d.halted", d), o_hlt[d], m_halt[d]);
      chk($sformatf("u%0d.illegal", d), o_ill[d], m_ill[d]);
      chk($sformatf("u%0d.pc_read_enable", d), o_pre[d], !reset && cur[d].st == 3'd0 && run);
      chk($sformatf("u%0d.pc_enable", d), o_pe[d], !reset && cur[d].pe);
      chk($sformatf("u%0d.alu_read_enable", d), o_ae[d], !reset && cur[d].ae);
      chk($sformatf("u%0d.ram_read_enable", d), o_re[d], !reset && cur[d].re);
      chk($sformatf("u%0d.onehot", d), ($countones({o_pre[d], o_ae[d], o_re[d]}) <= 1), 1);
    end
  end

  // ---------------- stimulus and hand-computed pins
  task automatic drive(); @(posedge clk); #2; endtask
  task automatic sample(); @(negedge clk); #1; endtask
  task automatic rst();
    drive(); reset = 1'b1; run = 1'b0;
    drive(); drive(); reset = 1'b0;
  endtask

  function automatic logic [15:0] rand_op();
    logic [31:0] r;
    r = $urandom;
    case ($urandom_range(0, 11))
      0, 1:    return {4'h1, r[11:0]};
      2, 3:    return {4'h3, r[11:0]};
      4, 5:    return {4'h4, r[11:0]};
      6, 7:    return {4'h7, r[11:0]};
      8:       return 16'h0000;
      9:       return r[15:0];
      10:      return {4'h0, r[11:0] | 12'h001};
      default: return {4'h4, r[11:0]};
    endcase
  endfunction

  initial begin
    // Test 1: ALU op timeline
    rst(); rom_op = 16'h1203; rom_opd = 16'h0005; run = 1'b1;
    sample(); chk("t1_c0_state", o_st[0], 0); chk("t1_c0_pre", o_pre[0], 1);
    drive(); run = 1'b0;
    sample(); chk("t1_c1_state", o_st[0], 1); chk("t1_c1_ir", o_op[0], 16'h1203);
    chk("t1_c1_opd", o_opd[0], 16'h0005);
    drive(); sample(); chk("t1_c2_ae", o_ae[0], 1);
    drive(); sample(); chk("t1_c3_pe", o_pe[0], 1); chk("t1_c3_cnt", o_cnt[0], 1);
    drive(); sample(); chk("t1_c4_state", o_st[0], 0);

    // Test 2: RAM op with latency 3
    rst(); rom_op = 16'h4100; run = 1'b1;
    for (int c = 0; c < 7; c++) begin
      if (c > 0) begin drive(); run = 1'b0; end
      sample();
      chk($sformatf("t2_c%0d_re", c), o_re[0], (c >= 2 && c <= 4) ? 1 : 0);
      if (c == 5) begin chk("t2_c5_state", o_st[0], 4); chk("t2_c5_pe", o_pe[0], 1); end
    end

    // Test 3: PC op, no extra increment at retire
    rst(); rom_op = 16'h7001; run = 1'b1;
    drive(); run = 1'b0;
    drive(); sample(); chk("t3_c2_pe", o_pe[0], 1);
    drive(); sample(); chk("t3_c3_pe", o_pe[0], 0); chk("t3_c3_cnt", o_cnt[0], 1);

    // Test 4: halt and illegal
    rst(); rom_op = 16'h0000; run = 1'b1;
    drive(); run = 1'b0;
    drive(); sample();
    chk("t4_state", o_st[0], 5); chk("t4_halted", o_hlt[0], 1); chk("t4_illegal", o_ill[0], 0);
    for (int i = 0; i < 20; i++) begin
      drive(); run = $urandom_range(0, 1); rom_op = $urandom;
      sample();
      chk("t4_en_off", {o_pre[0], o_pe[0], o_ae[0], o_re[0]}, 0);
    end
    rst(); rom_op = 16'h9000; run = 1'b1;
    drive(); run = 1'b0;
    drive(); sample(); chk("t4_ill_halted", o_hlt[0], 1); chk("t4_ill_illegal", o_ill[0], 1);

    // Test 5: run held low
    rst();
    for (int i = 0; i < 5; i++) begin
      sample(); chk("t5_state", o_st[0], 0); chk("t5_pre", o_pre[0], 0);
      drive();
    end
    rom_op = 16'h3000; run = 1'b1;
    sample(); chk("t5_pre_up", o_pre[0], 1);
    drive(); run = 1'b0;
    sample(); chk("t5_decode", o_st[0], 1);
    drive(); drive(); drive();

    // Test 6a: reset while waiting on RAM
    rst(); rom_op = 16'h1000; run = 1'b1;
    drive(); run = 1'b0;
    drive(); drive(); drive();
    rom_op = 16'h4100; run = 1'b1;
    drive(); run = 1'b0;
    drive(); drive();
    sample(); chk("t6_wait_state", o_st[0], 3); chk("t6_wait_cnt", o_cnt[0], 1);
    drive(); reset = 1'b1; #1;
    chk("t6_rst_state", o_st[0], 0);
    chk("t6_rst_en", {o_pre[0], o_pe[0], o_ae[0], o_re[0]}, 0);
    chk("t6_rst_cnt", o_cnt[0], 0);
    drive(); reset = 1'b0;

    // Test 6b: counter wrap on the 4-bit instance
    rst();
    for (int i = 0; i < 16; i++) begin
      rom_op = {4'h3, 12'($urandom)}; run = 1'b1;
      drive(); run = 1'b0;
      drive(); drive(); drive();
      if (i == 14) begin sample(); chk("t6_cnt15", o_cnt[1], 16'h000F); end
    end
    sample(); chk("t6_wrap_u1", o_cnt[1], 0); chk("t6_cnt_u0", o_cnt[0], 16'h0010);

    // Random programs with occasional reset
    rst();
    for (int i = 0; i < 1500; i++) begin
      drive();
      reset   = ($urandom_range(0, 59) == 0);
      run     = ($urandom_range(0, 3) != 0);
      rom_op  = rand_op();
      rom_opd = $urandom;
    end
    drive(); reset = 1'b0;
    drive();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
